// File: rtl/motor_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : motor_ramp_ctrl_if
// Description : Signal bundle between the command logic (master) and the
//               motor ramp sequencer (slave).
//                 start     - level run request (master -> slave)
//                 target    - requested 2-bit speed code (master -> slave)
//                 estop     - emergency stop (master -> slave, RAMP_ESTOP_EN)
//                 speed     - speed code to the PWM block (slave -> master)
//                 motor_en  - PWM output gate (slave -> master)
//                 busy      - ramping or stopping (slave -> master)
//                 at_target - running at the requested speed (slave -> master)
//                 fault     - latched emergency stop (slave -> master,
//                             RAMP_ESTOP_EN)
//               Optional feature macro: RAMP_ESTOP_EN
// Revision    : 1.0 - initial release
// ============================================================================
interface motor_ramp_ctrl_if;
    logic       start;
    logic [1:0] target;
    logic [1:0] speed;
    logic       motor_en;
    logic       busy;
    logic       at_target;
`ifdef RAMP_ESTOP_EN
    logic       estop;
    logic       fault;

    modport master (
        output start,
        output target,
        output estop,
        input  speed,
        input  motor_en,
        input  busy,
        input  at_target,
        input  fault
    );

    modport slave (
        input  start,
        input  target,
        input  estop,
        output speed,
        output motor_en,
        output busy,
        output at_target,
        output fault
    );
`else
    modport master (
        output start,
        output target,
        input  speed,
        input  motor_en,
        input  busy,
        input  at_target
    );

    modport slave (
        input  start,
        input  target,
        output speed,
        output motor_en,
        output busy,
        output at_target
    );
`endif
endinterface : motor_ramp_ctrl_if
`default_nettype wire

// File: rtl/motor_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : motor_ramp_ctrl
// Description : Soft-start / soft-stop sequencer for the motor PWM block.
//               Moves the 2-bit speed code one step at a time toward the
//               requested target, holding every step for STEP_CYCLES clocks,
//               and gates the PWM output off when idle.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - motor_ramp_ctrl_if.slave
//                        (start/target/estop in; speed/motor_en/busy/
//                         at_target/fault out)
// Parameters  : STEP_CYCLES - dwell per speed step in clocks (2..65536)
// Options     : RAMP_ESTOP_EN - adds the estop input and latched fault output
// Revision    : 1.0 - initial release
// ============================================================================
module motor_ramp_ctrl #(
    parameter int STEP_CYCLES = 1024
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    motor_ramp_ctrl_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               CNT_W      = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state_q,     state_d;
    logic [1:0]       speed_q,     speed_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             motor_en_q,  motor_en_d;
    logic             busy_q,      busy_d;
    logic             at_target_q, at_target_d;
`ifdef RAMP_ESTOP_EN
    logic             fault_q,     fault_d;
`endif

    logic             w_expiry;
    logic             w_start_ok;
    logic [1:0]       w_step_speed;

    assign w_expiry = (cnt_q == CNT_ZERO);

    // A latched fault masks the run request until it has been cleared.
`ifdef RAMP_ESTOP_EN
    assign w_start_ok = bus.start & ~fault_q;
`else
    assign w_start_ok = bus.start;
`endif

    // One step toward the target; only used when speed differs from target,
    // so the +1/-1 can never wrap.
    assign w_step_speed = (bus.target > speed_q) ? (speed_q + 2'd1)
                                                 : (speed_q - 2'd1);

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        cnt_d    = cnt_q;
`ifdef RAMP_ESTOP_EN
        fault_d  = fault_q;
`endif

        // The dwell counter free-runs outside IDLE; individual transitions
        // below override it with a reload where a fresh dwell is needed.
        if (state_q != ST_IDLE) begin
            cnt_d = w_expiry ? CNT_RELOAD : (cnt_q - 1'b1);
        end

        case (state_q)
            ST_IDLE: begin
                if (w_start_ok) begin
                    state_d = ST_RAMP;
                    speed_d = 2'd0;
                    cnt_d   = CNT_RELOAD;
                end
            end

            ST_RAMP: begin
                // Dropping the request aborts the ramp but keeps the dwell
                // phase, so the current step still gets its full time.
                if (!bus.start) begin
                    state_d = ST_STOP;
                end else if (speed_q == bus.target) begin
                    state_d = ST_RUN;
                end else if (w_expiry) begin
                    speed_d = w_step_speed;
                    if (w_step_speed == bus.target) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (!bus.start) begin
                    state_d = ST_STOP;
                    cnt_d   = CNT_RELOAD;
                end else if (speed_q != bus.target) begin
                    state_d = ST_RAMP;
                    cnt_d   = CNT_RELOAD;
                end
            end

            ST_STOP: begin
                // Speed 0 is also held for a full dwell before the gate
                // closes, so the motor always sees a complete 25 % step.
                if (bus.start) begin
                    state_d = ST_RAMP;
                end else if (w_expiry) begin
                    if (speed_q != 2'd0) begin
                        speed_d = speed_q - 2'd1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                speed_d = 2'd0;
                cnt_d   = CNT_ZERO;
            end
        endcase

`ifdef RAMP_ESTOP_EN
        // Emergency stop overrides everything decided above.
        if (bus.estop) begin
            state_d = ST_IDLE;
            speed_d = 2'd0;
            cnt_d   = CNT_ZERO;
            fault_d = 1'b1;
        end else if (fault_q && !bus.start) begin
            fault_d = 1'b0;
        end
`endif

        // Status outputs are registered copies of the next state.
        motor_en_d  = (state_d != ST_IDLE);
        busy_d      = (state_d == ST_RAMP) || (state_d == ST_STOP);
        at_target_d = (state_d == ST_RUN);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            speed_q     <= 2'd0;
            cnt_q       <= CNT_ZERO;
            motor_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
`ifdef RAMP_ESTOP_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            cnt_q       <= cnt_d;
            motor_en_q  <= motor_en_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
`ifdef RAMP_ESTOP_EN
            fault_q     <= fault_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.speed     = speed_q;
    assign bus.motor_en  = motor_en_q;
    assign bus.busy      = busy_q;
    assign bus.at_target = at_target_q;
`ifdef RAMP_ESTOP_EN
    assign bus.fault     = fault_q;
`endif

endmodule : motor_ramp_ctrl
`default_nettype wire

// File: doc/motor_ramp_ctrl.md
# motor_ramp_ctrl

Soft-start/soft-stop sequencer that drives the 2-bit `speed` code and the enable gate of the motor PWM generator. It turns a level run request and a target speed into a controlled ramp: the speed code moves one step (25 % duty) at a time, each step held for a fixed dwell. Because the PWM block's slowest code still gives 25 % duty, `motor_en` gates the PWM output fully off when idle. Sits between the control/command logic and the PWM block.

## Interface
- `STEP_CYCLES`, 1024, clock cycles per speed step (dwell); legal range 2..65536
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level run request; high = run at `target`, low = ramp down and stop
- `target`  in  2  requested speed code, 0..3 (25/50/75/100 %)
- `estop`  in  1  emergency stop, active high (only with `RAMP_ESTOP_EN`)
- `speed`  out  2  speed code to the PWM block
- `motor_en`  out  1  PWM output gate; 0 = motor off regardless of `speed`
- `busy`  out  1  high in RAMP or STOP
- `at_target`  out  1  high in RUN (`speed == target`, stable)
- `fault`  out  1  latched emergency-stop flag (only with `RAMP_ESTOP_EN`)

## Operation
- All outputs are registered. Reset state: IDLE, `speed`=0, `motor_en`=0, `busy`=0, `at_target`=0, `fault`=0, dwell counter=0.
- Dwell counter width is $clog2(STEP_CYCLES). Reload value is STEP_CYCLES-1. The counter decrements every cycle outside IDLE. "Expiry" means the counter is 0; the counter reloads on expiry.
- IDLE:
  - When `start`=1 → RAMP, with `motor_en`=1, `speed`=0, counter reloaded.
- RAMP:
  - If `speed==target`, → RUN on the next edge.
  - Otherwise, on expiry `speed` moves one step toward `target` (±1). If the new value equals `target`, → RUN on the same edge.
  - `target` is re-evaluated at every edge. A mid-dwell change of `target` does not reload the counter. It can reverse the step direction.
- RUN:
  - `target` change → RAMP with counter reloaded.
  - `start`=0 → STOP with counter reloaded.
- STOP:
  - On expiry, if `speed`>0 then `speed` decrements.
  - On expiry with `speed`=0 → IDLE and `motor_en`=0.
- `start`=0 seen in RAMP → STOP. The counter is not reloaded.
- `start`=1 seen in STOP → RAMP. The counter is not reloaded, and ramping continues from the current `speed`.
- `speed` never changes by more than 1 per edge and never wraps (no 3→0 or 0→3).
- `speed` changes only on expiry.

## Timing
- Example: `start`=1 sampled in IDLE at edge k with `target`=3.
  - `motor_en`=1 and `busy`=1 after edge k.
  - `speed`=1 after k+S, 2 after k+2S, 3 after k+3S (S = STEP_CYCLES).
  - `at_target`=1 and `busy`=0 after k+3S.
- Example: `start`=1 sampled in IDLE at edge k with `target`=0.
  - RAMP after edge k, then RUN after edge k+1.
- Example: `start`=0 sampled in RUN at edge m with `speed`=3.
  - `speed`=2, 1, 0 after m+S, m+2S, m+3S.
  - `motor_en`=0 after m+4S, which guarantees a full dwell at 25 %.
- Example: `start`=0 sampled in RUN at edge m with `speed`=0.
  - `motor_en`=0 after m+S.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous). Operation resumes from IDLE after `rst_n` deasserts.

## Configuration
- `RAMP_ESTOP_EN` defined:
  - The `estop` and `fault` ports exist.
  - `estop`=1 at any edge, in any state, forces IDLE on that edge: `speed`=0, `motor_en`=0, `busy`=0, `at_target`=0, `fault`=1.
  - Estop has priority over all other transitions.
  - While `fault`=1, `start` is ignored.
  - `fault` clears on the first edge where `estop`=0 and `start`=0. A new rising request is needed to run again.
- `RAMP_ESTOP_EN` undefined:
  - The `estop` and `fault` ports and their logic are absent.
  - Behaviour is otherwise identical.

## Test plan
- Ramp up: STEP_CYCLES=4, reset, `start`=1, `target`=3.
  - Required: `speed` 0→1→2→3 at exact 4-cycle intervals.
  - Required: `at_target` rises together with `speed`=3.
  - Required: `motor_en`=1 one cycle after `start`.
- Ramp down: from RUN at 3, drop `start`.
  - Required: `speed` 3→2→1→0 at 4-cycle spacing.
  - Required: `motor_en` falls 4 cycles after `speed` reaches 0.
  - Required: `busy` is high throughout and low afterwards.
- Retarget: in RUN at 3, set `target`=1.
  - Required: RAMP with reload, then 3→2→1 at 4-cycle spacing.
  - Mid-dwell, set `target`=3. Required: direction reverses at the next expiry, with no reload.
- Abort and restart: drop `start` during RAMP at `speed`=2, then reassert `start` while in STOP at `speed`=1.
  - Required: ramp resumes upward from 1.
  - Required: `motor_en` never drops.
- Reset: assert `rst_n`=0 mid-ramp.
  - Required: all outputs are 0 immediately, without waiting for a clock edge.
  - Required: after release, the block stays in IDLE until `start` is high.
- Estop (`RAMP_ESTOP_EN`): pulse `estop` in RUN at 3.
  - Required: next edge gives `speed`=0, `motor_en`=0, `fault`=1.
  - Required: `start`=1 is ignored while `fault`=1.
  - Required: `fault` clears only once `start`=0 and `estop`=0.
